dmem_write_buffer: RTL

//   Posted-store buffer between the mips core's data port and dmem.
//   - Stores are queued in a DEPTH-entry FIFO; the core is stalled only when the FIFO is full.
//   - Stores drain to dmem one per cycle when dmem accepts them.
//   - Loads that hit a queued store are forwarded from the buffer; loads that miss read dmem directly.
//   - The core therefore keeps a single-cycle data-memory view while dmem may back-pressure.

---
 rtl/dmem_write_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the core data port and dmem: queues stores in a FIFO,
// drains them when dmem is ready, and forwards loads from the youngest matching store.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_memwrite,
    input  logic                         cpu_memread,
    input  logic [AW-1:0]                cpu_adr,
    input  logic [DW-1:0]                cpu_wdata,
    output logic [DW-1:0]                cpu_rdata,
    output logic                         stall,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_adr,
    output logic [DW-1:0]                mem_wdata,
    input  logic [DW-1:0]                mem_rdata,
    input  logic                         mem_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW-1:0]    r_adr  [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_hit;
    logic [DW-1:0]    w_fwd;
    logic             w_miss_load;
    logic             w_nonempty;
    logic             w_deq;
    logic             w_enq;

    // Walk oldest to youngest so the last match (the youngest store) wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_hit = 1'b0;
        w_fwd = '0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if (cpu_memread && r_valid[idx] &&
                (r_adr[idx][AW-1:2] == cpu_adr[AW-1:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[idx];
            end
        end
    end

    // Port arbitration: a missing load owns dmem; otherwise the head store drains.
    always_comb begin
        w_miss_load = cpu_memread & ~w_hit;
        w_nonempty  = (r_count != '0);
        w_deq       = w_nonempty & ~w_miss_load & mem_ready;
        stall       = cpu_memwrite & (r_count == CW'(DEPTH)) & ~w_deq;
        w_enq       = cpu_memwrite & ~stall;
        cpu_rdata   = w_hit ? w_fwd : mem_rdata;
        mem_we      = 1'b0;
        mem_adr     = cpu_adr;
        mem_wdata   = '0;
        if (!w_miss_load && w_nonempty) begin
            mem_adr   = r_adr[r_rd_ptr];
            mem_wdata = r_data[r_rd_ptr];
            mem_we    = mem_ready;
        end
    end

    // Pointer, occupancy and valid bookkeeping; enqueue set wins over dequeue clear on a full wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_deq) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            if (w_enq) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // Entry payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_adr[r_wr_ptr]  <= cpu_adr;
            r_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    assign count = r_count;

endmodule
